// File: rtl/rggen_rtl_pkg.sv
// ============================================================================
// rggen_rtl_pkg : shared status/state types and address helper for rggen RTL
// Revision: 1.0
// ============================================================================
`default_nettype none

package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    OKAY         = 2'b00,
    EXOKAY       = 2'b01,
    SLAVE_ERROR  = 2'b10,
    DECODE_ERROR = 2'b11
  } rggen_status;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SETUP    = 2'b01,
    ACCESS   = 2'b10,
    RESPONSE = 2'b11
  } rggen_apb_bridge_state;

  // Number of byte-offset address bits inside one data word.
  function automatic int rggen_address_lsb_width(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rggen_apb_bridge.sv
// ============================================================================
// rggen_apb_bridge : rggen local-bus command to APB4 initiator bridge.
// Optional ACCESS timeout: define RGGEN_APB_BRIDGE_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rggen_apb_bridge
  import rggen_rtl_pkg::*;
#(
  parameter int         DATA_WIDTH     = 32,
  parameter int         ADDRESS_WIDTH  = 16,
  parameter logic [2:0] PPROT_VALUE    = 3'h0,
  parameter int         TIMEOUT_CYCLES = 256
)(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_valid,
  input  logic                      i_write,
  input  logic                      i_read,
  input  logic [ADDRESS_WIDTH-1:0]  i_address,
  input  logic [DATA_WIDTH/8-1:0]   i_strobe,
  input  logic [DATA_WIDTH-1:0]     i_write_data,
  output logic                      o_ready,
  output logic [1:0]                o_status,
  output logic [DATA_WIDTH-1:0]     o_read_data,
  output logic [ADDRESS_WIDTH-1:0]  o_paddr,
  output logic [2:0]                o_pprot,
  output logic                      o_psel,
  output logic                      o_penable,
  output logic                      o_pwrite,
  output logic [DATA_WIDTH-1:0]     o_pwdata,
  output logic [DATA_WIDTH/8-1:0]   o_pstrb,
  input  logic                      i_pready,
  input  logic [DATA_WIDTH-1:0]     i_prdata,
  input  logic                      i_pslverr
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int LSB_WIDTH  = rggen_address_lsb_width(DATA_WIDTH);

  rggen_apb_bridge_state  state;
  rggen_apb_bridge_state  state_next;
  rggen_status            status;
  logic [DATA_WIDTH-1:0]  read_data;
  logic                   timeout_hit;

`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
  localparam int COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  logic [COUNT_WIDTH-1:0] access_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      access_count <= '0;
    end else if (state != ACCESS) begin
      access_count <= '0;
    end else if (!i_pready) begin
      access_count <= access_count + COUNT_WIDTH'(1);
    end
  end

  // A ready slave in the final allowed cycle still completes normally.
  assign timeout_hit = (access_count == COUNT_WIDTH'(TIMEOUT_CYCLES - 1)) && !i_pready;
`else
  // The timeout never fires in this build; ACCESS waits for the slave.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    o_psel     = 1'b0;
    o_penable  = 1'b0;
    o_ready    = 1'b0;
    case (state)
      IDLE: begin
        if (i_valid) begin
          state_next = (i_write || i_read) ? SETUP : RESPONSE;
        end
      end
      SETUP: begin
        o_psel     = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        o_psel    = 1'b1;
        o_penable = 1'b1;
        if (i_pready || timeout_hit) begin
          state_next = RESPONSE;
        end
      end
      default: begin
        o_ready    = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_paddr   <= '0;
      o_pwrite  <= 1'b0;
      o_pwdata  <= '0;
      o_pstrb   <= '0;
      status    <= OKAY;
      read_data <= '0;
    end else if ((state == IDLE) && i_valid) begin
      status    <= OKAY;
      read_data <= '0;
      if (i_write || i_read) begin
        // Write wins when both are set; reads carry no strobes on APB4.
        o_paddr  <= {i_address[ADDRESS_WIDTH-1:LSB_WIDTH], LSB_WIDTH'(0)};
        o_pwrite <= i_write;
        o_pwdata <= i_write_data;
        o_pstrb  <= i_write ? i_strobe : STRB_WIDTH'(0);
      end
    end else if (state == ACCESS) begin
      if (i_pready) begin
        status    <= i_pslverr ? SLAVE_ERROR : OKAY;
        read_data <= o_pwrite ? '0 : i_prdata;
      end else if (timeout_hit) begin
        status    <= SLAVE_ERROR;
        read_data <= '0;
      end
    end
  end

  assign o_status    = status;
  assign o_read_data = read_data;
  assign o_pprot     = PPROT_VALUE;

endmodule

`default_nettype wire

// File: tb/tb_rggen_apb_bridge.sv
// ============================================================================
// tb_rggen_apb_bridge : scoreboard bench for the rggen-to-APB4 bridge.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rggen_apb_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_write = 1'b0;
  logic        i_read = 1'b0;
  logic [15:0] i_address = '0;
  logic [3:0]  i_strobe = '0;
  logic [31:0] i_write_data = '0;
  logic        o_ready;
  logic [1:0]  o_status;
  logic [31:0] o_read_data;
  logic [15:0] o_paddr;
  logic [2:0]  o_pprot;
  logic        o_psel;
  logic        o_penable;
  logic        o_pwrite;
  logic [31:0] o_pwdata;
  logic [3:0]  o_pstrb;
  logic        i_pready = 1'b0;
  logic [31:0] i_prdata = '0;
  logic        i_pslverr = 1'b0;

  rggen_apb_bridge #(
    .DATA_WIDTH     (32),
    .ADDRESS_WIDTH  (16),
    .PPROT_VALUE    (3'h5),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (i_valid),
    .i_write      (i_write),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_strobe     (i_strobe),
    .i_write_data (i_write_data),
    .o_ready      (o_ready),
    .o_status     (o_status),
    .o_read_data  (o_read_data),
    .o_paddr      (o_paddr),
    .o_pprot      (o_pprot),
    .o_psel       (o_psel),
    .o_penable    (o_penable),
    .o_pwrite     (o_pwrite),
    .o_pwdata     (o_pwdata),
    .o_pstrb      (o_pstrb),
    .i_pready     (i_pready),
    .i_prdata     (i_prdata),
    .i_pslverr    (i_pslverr)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ready_count = 0;
  int setup_count = 0;
  logic [33:0] exp_q[$];

  int          sl_waits = 0;
  logic        sl_err = 1'b0;
  logic [31:0] sl_rdata = '0;

  int          r_lat, r_pen, r_setup, r_ready, r_unstable;
  logic [15:0] s_paddr;
  logic [3:0]  s_pstrb;
  logic        s_pwrite;
  logic [31:0] s_pwdata;

  initial forever begin
    #5 clk = ~clk;
    if (clk) cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // APB slave: pready after sl_waits wait states in ACCESS.
  initial begin
    int acc = 0;
    forever begin
      @(negedge clk);
      if (o_psel && o_penable) begin
        i_pready  = (acc == sl_waits);
        i_pslverr = i_pready && sl_err;
        i_prdata  = i_pready ? sl_rdata : 32'h0;
        acc++;
      end else begin
        acc       = 0;
        i_pready  = 1'b0;
        i_pslverr = 1'b0;
        i_prdata  = 32'h0;
      end
    end
  end

  // Response monitor: pops the scoreboard on every o_ready pulse.
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (o_psel && !o_penable) setup_count++;
        if (o_ready) begin
          ready_count++;
          if (exp_q.size() == 0) begin
            check("unexpected_ready", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("resp_status", o_status, e[33:32]);
            check("resp_data", o_read_data, e[31:0]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Caller must be at a falling edge; returns at a falling edge.
  task automatic do_cmd(input logic w, input logic r, input logic [15:0] a, input logic [3:0] s,
                        input logic [31:0] d, input int waits, input logic err,
                        input logic [31:0] rdata, input logic [1:0] exp_st,
                        input logic [31:0] exp_rd, input bit keep);
    exp_q.push_back({exp_st, exp_rd});
    sl_waits = waits;
    sl_err   = err;
    sl_rdata = rdata;
    i_valid = 1'b1; i_write = w; i_read = r;
    i_address = a; i_strobe = s; i_write_data = d;
    r_lat = 0; r_pen = 0; r_setup = -1; r_ready = -1; r_unstable = 0;
    while (r_ready < 0 && r_lat < 60) begin
      @(posedge clk);
      r_lat++;
      @(negedge clk);
      #1;
      if (o_psel && !o_penable && r_setup < 0) begin
        r_setup = cyc;
        s_paddr = o_paddr; s_pstrb = o_pstrb; s_pwrite = o_pwrite; s_pwdata = o_pwdata;
      end
      if (o_psel && r_setup >= 0 &&
          (o_paddr !== s_paddr || o_pstrb !== s_pstrb ||
           o_pwrite !== s_pwrite || o_pwdata !== s_pwdata)) r_unstable++;
      if (o_penable) r_pen++;
      if (o_ready) r_ready = cyc;
    end
    check("handshake_done", (r_ready >= 0), 1);
    if (!keep) begin
      i_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int rc, sc, first_ready;
    repeat (2) @(negedge clk);
    check("rst_psel", o_psel, 0);
    check("rst_penable", o_penable, 0);
    check("rst_ready", o_ready, 0);
    check("rst_status", o_status, 2'b00);
    check("rst_read_data", o_read_data, 0);
    check("rst_paddr", o_paddr, 0);
    check("rst_pwrite", o_pwrite, 0);
    check("rst_pwdata", o_pwdata, 0);
    check("rst_pstrb", o_pstrb, 0);
    check("pprot", o_pprot, 3'h5);
    rst_n = 1'b1;
    @(negedge clk);

    do_cmd(1, 0, 16'h0006, 4'b0011, 32'h1234_5678, 0, 0, 32'h0, 2'b00, 32'h0, 0);
    check("wr_latency", r_lat, 3);
    check("wr_paddr", s_paddr, 16'h0004);
    check("wr_pstrb", s_pstrb, 4'b0011);
    check("wr_pwrite", s_pwrite, 1);
    check("wr_pwdata", s_pwdata, 32'h1234_5678);
    check("wr_penable_cycles", r_pen, 1);
    check("wr_stable", r_unstable, 0);

    do_cmd(0, 1, 16'h0010, 4'b1111, 32'hFFFF_FFFF, 3, 0, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 0);
    check("rd_pstrb", s_pstrb, 4'b0000);
    check("rd_pwrite", s_pwrite, 0);
    check("rd_paddr", s_paddr, 16'h0010);
    check("rd_penable_cycles", r_pen, 4);
    check("rd_latency", r_lat, 6);
    check("rd_stable", r_unstable, 0);

    rc = ready_count;
    do_cmd(1, 0, 16'h0020, 4'b1000, 32'hA5A5_0000, 1, 1, 32'h0, 2'b10, 32'h0, 0);
    repeat (3) @(negedge clk);
    check("err_ready_pulses", ready_count - rc, 1);

    do_cmd(1, 1, 16'hABCF, 4'b0101, 32'hCAFE_F00D, 0, 0, 32'h1111_1111, 2'b00, 32'h0, 0);
    check("both_pwrite", s_pwrite, 1);
    check("both_pstrb", s_pstrb, 4'b0101);
    check("both_paddr", s_paddr, 16'hABCC);

    sc = setup_count;
    do_cmd(0, 0, 16'h0040, 4'hF, 32'h0, 0, 0, 32'h0, 2'b00, 32'h0, 0);
    check("nop_latency", r_lat, 1);
    check("nop_no_setup", setup_count - sc, 0);

    sc = setup_count;
    rc = ready_count;
    do_cmd(0, 1, 16'h0100, 4'hF, 32'h0, 1, 0, 32'h0BAD_F00D, 2'b00, 32'h0BAD_F00D, 1);
    first_ready = r_ready;
    do_cmd(0, 1, 16'h0104, 4'hF, 32'h0, 0, 0, 32'h600D_CAFE, 2'b00, 32'h600D_CAFE, 0);
    check("b2b_setup_after_ready", r_setup - first_ready, 2);
    check("b2b_paddr", s_paddr, 16'h0104);
    repeat (5) @(negedge clk);
    check("b2b_setups", setup_count - sc, 2);
    check("b2b_readies", ready_count - rc, 2);

    sl_waits = 20;
    i_valid = 1'b1; i_write = 1'b1; i_read = 1'b0;
    i_address = 16'h0200; i_strobe = 4'hF; i_write_data = 32'h7777_0000;
    repeat (3) @(negedge clk);
    #1;
    check("rst_pre_penable", o_penable, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_psel", o_psel, 0);
    check("rst_mid_penable", o_penable, 0);
    check("rst_mid_ready", o_ready, 0);
    check("rst_mid_paddr", o_paddr, 0);
    i_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_cmd(1, 0, 16'h0300, 4'b1100, 32'h5555_AAAA, 0, 0, 32'h0, 2'b00, 32'h0, 0);
    check("post_rst_latency", r_lat, 3);
    check("post_rst_paddr", s_paddr, 16'h0300);

`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
    do_cmd(0, 1, 16'h0400, 4'hF, 32'h0, 100, 0, 32'hFFFF_FFFF, 2'b10, 32'h0, 0);
    check("to_penable_cycles", r_pen, 4);
    check("to_latency", r_lat, 6);
`endif

    repeat (3) @(negedge clk);
    check("pending_resp", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
